// File: rtl/clock_phase_manager.sv
// rtl/clock_phase_manager.sv - multi-phase one-hot timing generator with programmable per-phase dwell
// Single-clock phase enables; free-run, single-step, clean stop, abort, completed-cycle counter.
module clock_phase_manager #(
    parameter int N_PHASES = 4,
    parameter int DIV_W    = 3,
    parameter int CYC_W    = 16,
    localparam int IDX_W   = $clog2(N_PHASES)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      step_mode,
    input  logic                      step,
    input  logic                      abort,
    input  logic [N_PHASES*DIV_W-1:0] dwell,
    output logic [N_PHASES-1:0]       phase_en,
    output logic [IDX_W-1:0]          phase_idx,
    output logic                      cycle_done,
    output logic [CYC_W-1:0]          cycle_count,
    output logic                      busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_STEP = 2'd2
    } state_t;

    state_t                      state_q, state_d;
    logic [IDX_W-1:0]            phase_q, phase_d;
    logic [DIV_W-1:0]            cnt_q, cnt_d;
    logic [N_PHASES*DIV_W-1:0]   shadow_q, shadow_d;
    logic [N_PHASES-1:0]         phase_en_q, phase_en_d;
    logic                        cycle_done_q, cycle_done_d;
    logic [CYC_W-1:0]            cycle_count_q, cycle_count_d;
    logic [DIV_W-1:0]            cur_dwell;
    logic                        phase_last;
    logic                        cycle_last;

    // Dwell of the active phase, taken from the shadow copy so mid-cycle edits are invisible
    always_comb begin
        cur_dwell = '0;
        for (int k = 0; k < N_PHASES; k++) begin
            if (phase_q == IDX_W'(k)) begin
                cur_dwell = shadow_q[k*DIV_W +: DIV_W];
            end
        end
    end

    assign phase_last = (cnt_q == cur_dwell);
    assign cycle_last = phase_last && (phase_q == IDX_W'(N_PHASES - 1));

    always_comb begin
        state_d       = state_q;
        phase_d       = phase_q;
        cnt_d         = cnt_q;
        shadow_d      = shadow_q;
        phase_en_d    = phase_en_q;
        cycle_done_d  = 1'b0;
        cycle_count_d = cycle_count_q;

        case (state_q)
            S_IDLE: begin
                if (!abort) begin
                    if (!step_mode && enable) begin
                        state_d    = S_RUN;
                        phase_d    = '0;
                        cnt_d      = '0;
                        shadow_d   = dwell;
                        phase_en_d = N_PHASES'(1);
                    end else if (step_mode && step) begin
                        state_d    = S_STEP;
                        phase_d    = '0;
                        cnt_d      = '0;
                        shadow_d   = dwell;
                        phase_en_d = N_PHASES'(1);
                    end
                end
            end
            default: begin
                if (abort) begin
                    state_d    = S_IDLE;
                    phase_d    = '0;
                    cnt_d      = '0;
                    phase_en_d = '0;
                end else if (cycle_last) begin
                    cycle_done_d  = 1'b1;
                    cycle_count_d = cycle_count_q + CYC_W'(1);
                    phase_d       = '0;
                    cnt_d         = '0;
                    if (state_q == S_RUN && enable) begin
                        shadow_d   = dwell;
                        phase_en_d = N_PHASES'(1);
                    end else begin
                        state_d    = S_IDLE;
                        phase_en_d = '0;
                    end
                end else if (phase_last) begin
                    phase_d    = phase_q + IDX_W'(1);
                    cnt_d      = '0;
                    phase_en_d = phase_en_q << 1;
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            phase_q       <= '0;
            cnt_q         <= '0;
            shadow_q      <= '0;
            phase_en_q    <= '0;
            cycle_done_q  <= 1'b0;
            cycle_count_q <= '0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            cnt_q         <= cnt_d;
            shadow_q      <= shadow_d;
            phase_en_q    <= phase_en_d;
            cycle_done_q  <= cycle_done_d;
            cycle_count_q <= cycle_count_d;
        end
    end

    assign phase_en    = phase_en_q;
    assign phase_idx   = phase_q;
    assign cycle_done  = cycle_done_q;
    assign cycle_count = cycle_count_q;
    assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_clock_phase_manager.sv
// tb/tb_clock_phase_manager.sv - directed self-checking bench for clock_phase_manager
module tb_clock_phase_manager;

    localparam int N_PHASES = 4;
    localparam int DIV_W    = 3;
    localparam int CYC_W    = 2;

    logic                      clock;
    logic                      reset;
    logic                      enable;
    logic                      step_mode;
    logic                      step;
    logic                      abort;
    logic [N_PHASES*DIV_W-1:0] dwell;
    logic [N_PHASES-1:0]       phase_en;
    logic [1:0]                phase_idx;
    logic                      cycle_done;
    logic [CYC_W-1:0]          cycle_count;
    logic                      busy;

    int errors = 0;
    int checks = 0;

    clock_phase_manager #(
        .N_PHASES(N_PHASES),
        .DIV_W   (DIV_W),
        .CYC_W   (CYC_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .step_mode  (step_mode),
        .step       (step),
        .abort      (abort),
        .dwell      (dwell),
        .phase_en   (phase_en),
        .phase_idx  (phase_idx),
        .cycle_done (cycle_done),
        .cycle_count(cycle_count),
        .busy       (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Inputs change and outputs are sampled on the falling edge, mid-way between active edges
    task automatic cyc();
        @(negedge clock);
    endtask

    task automatic do_reset();
        cyc();
        reset     = 1'b1;
        enable    = 1'b0;
        step_mode = 1'b0;
        step      = 1'b0;
        abort     = 1'b0;
        dwell     = '0;
        cyc();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cyc();
            checks++;
            if (phase_en !== 4'b0000 || busy !== 1'b0 || cycle_count !== 2'd0 ||
                phase_idx !== 2'd0 || cycle_done !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle clk%0d: en=%b busy=%b cnt=%0d idx=%0d done=%b, want 0000/0/0/0/0",
                         i, phase_en, busy, cycle_count, phase_idx, cycle_done);
            end
        end
    endtask

    task automatic test_free_run();
        logic [3:0] exp_en;
        logic       exp_done;
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 13; i++) begin
            cyc();
            exp_en   = 4'b0001 << (i % 4);
            exp_done = (i >= 4) && (i % 4 == 0);
            checks++;
            if (phase_en !== exp_en || cycle_done !== exp_done || busy !== 1'b1) begin
                errors++;
                $display("FAIL free_run clk%0d: en=%b done=%b busy=%b, want %b/%b/1",
                         i, phase_en, cycle_done, busy, exp_en, exp_done);
            end
        end
        checks++;
        if (cycle_count !== 2'd3) begin
            errors++;
            $display("FAIL free_run_count: got %0d want 3", cycle_count);
        end
    endtask

    task automatic test_variable_dwell();
        int exp_idx[12] = '{0, 1, 1, 2, 3, 3, 3, 0, 1, 2, 3, 0};
        logic [3:0] exp_en;
        logic       exp_done;
        do_reset();
        dwell  = {3'd2, 3'd0, 3'd1, 3'd0};
        enable = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cyc();
            exp_en   = 4'b0001 << exp_idx[i];
            exp_done = (i == 7) || (i == 11);
            checks++;
            if (phase_idx !== 2'(exp_idx[i]) || phase_en !== exp_en || cycle_done !== exp_done) begin
                errors++;
                $display("FAIL var_dwell clk%0d: idx=%0d en=%b done=%b, want %0d/%b/%b",
                         i, phase_idx, phase_en, cycle_done, exp_idx[i], exp_en, exp_done);
            end
            if (i == 2) dwell = '0;
        end
    endtask

    task automatic test_clean_stop();
        logic [3:0] exp_en[6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0000};
        logic       exp_done[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic       exp_busy[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc();
            checks++;
            if (phase_en !== exp_en[i] || cycle_done !== exp_done[i] || busy !== exp_busy[i]) begin
                errors++;
                $display("FAIL clean_stop clk%0d: en=%b done=%b busy=%b, want %b/%b/%b",
                         i, phase_en, cycle_done, busy, exp_en[i], exp_done[i], exp_busy[i]);
            end
            if (i == 1) enable = 1'b0;
        end
        checks++;
        if (cycle_count !== 2'd1) begin
            errors++;
            $display("FAIL clean_stop_count: got %0d want 1", cycle_count);
        end
    endtask

    task automatic test_single_step();
        logic [3:0] exp_en[7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
        logic       exp_done[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        do_reset();
        step_mode = 1'b1;
        enable    = 1'b1;
        step      = 1'b1;
        for (int i = 0; i < 7; i++) begin
            cyc();
            checks++;
            if (phase_en !== exp_en[i] || cycle_done !== exp_done[i] || busy !== (exp_en[i] != 4'b0000)) begin
                errors++;
                $display("FAIL single_step clk%0d: en=%b done=%b busy=%b, want %b/%b",
                         i, phase_en, cycle_done, busy, exp_en[i], exp_done[i]);
            end
            step = (i == 1);
        end
        checks++;
        if (cycle_count !== 2'd1) begin
            errors++;
            $display("FAIL single_step_count: got %0d want 1", cycle_count);
        end
    endtask

    task automatic test_abort();
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            checks++;
            if (phase_en !== (4'b0001 << i)) begin
                errors++;
                $display("FAIL abort_pre clk%0d: en=%b want %b", i, phase_en, 4'b0001 << i);
            end
        end
        abort = 1'b1;
        cyc();
        checks++;
        if (phase_en !== 4'b0000 || phase_idx !== 2'd0 || busy !== 1'b0 ||
            cycle_done !== 1'b0 || cycle_count !== 2'd0) begin
            errors++;
            $display("FAIL abort_end: en=%b idx=%0d busy=%b done=%b cnt=%0d, want 0000/0/0/0/0",
                     phase_en, phase_idx, busy, cycle_done, cycle_count);
        end
        cyc();
        checks++;
        if (busy !== 1'b0 || phase_en !== 4'b0000) begin
            errors++;
            $display("FAIL abort_idle_suppress: busy=%b en=%b, want 0/0000", busy, phase_en);
        end
        abort = 1'b0;
        cyc();
        checks++;
        if (phase_en !== 4'b0001 || busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_restart: en=%b busy=%b, want 0001/1", phase_en, busy);
        end
    endtask

    task automatic test_wrap();
        int         seen;
        logic [1:0] exp_cnt[5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        do_reset();
        enable = 1'b1;
        seen   = 0;
        for (int i = 0; i < 22; i++) begin
            cyc();
            if (i >= 4 && i % 4 == 0 && seen < 5) begin
                checks++;
                if (cycle_done !== 1'b1 || cycle_count !== exp_cnt[seen]) begin
                    errors++;
                    $display("FAIL wrap cyc%0d: done=%b cnt=%0d, want 1/%0d",
                             seen, cycle_done, cycle_count, exp_cnt[seen]);
                end
                seen++;
            end
        end
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (phase_en !== 4'b0000 || busy !== 1'b0 || cycle_count !== 2'd0 ||
            phase_idx !== 2'd0 || cycle_done !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: en=%b busy=%b cnt=%0d idx=%0d done=%b, want all 0",
                     phase_en, busy, cycle_count, phase_idx, cycle_done);
        end
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        enable    = 1'b0;
        step_mode = 1'b0;
        step      = 1'b0;
        abort     = 1'b0;
        dwell     = '0;
        test_reset();
        test_free_run();
        test_variable_dwell();
        test_clean_stop();
        test_single_step();
        test_abort();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/clock_phase_manager.md
Name: clock_phase_manager

Overview:
- Parametrised multi-phase timing generator for the nRisc pipeline. It produces one-hot phase enables on a single clock instead of divided clocks.
- Each phase has a programmable dwell length. Supports free-run and single-step modes, clean stop at cycle boundaries, immediate abort, and a completed-cycle counter.
- Downstream pipeline stages gate their registers with phase_en[k].

Parameters:
- N_PHASES, 4, number of phases per machine cycle (>=2).
- DIV_W, 3, width of each per-phase dwell field.
- CYC_W, 16, width of the completed-cycle counter.
- IDX_W, $clog2(N_PHASES), width of phase_idx (derived, not overridden).

Ports:
- clock  in  1  system clock; all state changes on posedge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  free-run request; level-sensitive.
- step_mode  in  1  0 = free-run, 1 = single-step; sampled only in IDLE.
- step  in  1  single-cycle request pulse; honoured only in IDLE with step_mode=1.
- abort  in  1  synchronous immediate stop; overrides everything except reset.
- dwell  in  N_PHASES*DIV_W  field k = extra cycles for phase k. Phase k lasts dwell_k+1 clocks.
- phase_en  out  N_PHASES  registered one-hot phase enable; all-zero when idle.
- phase_idx  out  IDX_W  index of the active phase; 0 when idle.
- cycle_done  out  1  one-clock pulse per completed machine cycle.
- cycle_count  out  CYC_W  number of completed cycles, modulo 2^CYC_W.
- busy  out  1  high in RUN or STEP.

Behaviour:
- Reset (async, any time): state=IDLE; phase_en=0; phase_idx=0; dwell counter=0; cycle_done=0; cycle_count=0; busy=0; shadow dwell=0.
- States:
  - IDLE: no phase enables.
  - RUN: free-running cycles.
  - STEP: exactly one cycle, then return.
- IDLE -> RUN when enable=1 and step_mode=0 at a posedge.
- IDLE -> STEP when step=1 and step_mode=1 at a posedge.
  - enable is ignored while step_mode=1.
  - step is ignored outside IDLE.
- Latency from start request: request sampled at edge E. phase_en=1<<0, phase_idx=0 and busy=1 become visible after E.
- Dwell handling:
  - The dwell vector is captured into a shadow register at every entry to phase 0.
  - Dwell changes take effect only from the next cycle start; no mid-cycle changes.
- Phase advance:
  - Phase k holds for shadow_dwell_k+1 consecutive clocks, then phase k+1 asserts on the next clock. There are no gap cycles.
  - phase_en is always exactly one-hot while busy=1.
- End of cycle, i.e. the last clock of phase N_PHASES-1:
  - At the following edge, cycle_done=1 for exactly one clock and cycle_count increments.
  - cycle_count wraps from 2^CYC_W-1 to 0.
  - In RUN with enable=1: wrap to phase 0 with no gap. cycle_done and phase_en[0] are high together.
  - In RUN with enable=0: go to IDLE. phase_en=0 and cycle_done=1 in the same clock.
  - In STEP: always go to IDLE in the same manner.
- enable deasserted mid-cycle: the current cycle completes fully. Stopping happens only at the cycle boundary.
- enable re-asserted before the boundary: RUN continues with no interruption.
- abort=1 at any edge while busy:
  - Next clock: IDLE, phase_en=0, phase_idx=0, dwell counter=0, busy=0.
  - No cycle_done pulse and no cycle_count increment, even if the edge coincides with the cycle end.
- abort in IDLE: no effect, and it suppresses a simultaneous start request.
- abort and reset together: reset wins.
- step_mode change while busy: no effect until the next IDLE.
- All-zero dwell: every phase lasts 1 clock, giving a cycle length of N_PHASES clocks.
- Maximum dwell: each phase lasts 2^DIV_W clocks.

Test Plan:
- Reset/idle: N=4, dwell=0, enable=0 for 10 clocks -> phase_en=0000, busy=0, cycle_count=0. Assert reset mid-RUN -> all outputs 0 immediately, without waiting for a clock edge.
- Free-run: dwell=0, enable=1 -> phase_en sequence 0001,0010,0100,1000,0001,... with no gaps. cycle_done pulses every 4 clocks, coincident with 0001 from the second cycle. cycle_count=3 after 12 clocks of RUN plus one edge.
- Variable dwell: dwell phases 0..3 = {0,1,0,2} -> phase durations 1,2,1,3 clocks, period 7. Change dwell mid-cycle to all 0 -> new timing only from the next phase-0 entry.
- Clean stop: drop enable during phase 1 -> phases 1..3 complete, then phase_en=0000 with cycle_done=1 in that clock, then busy=0.
- Single step: step_mode=1, pulse step once -> exactly one 4-phase cycle, cycle_count+1, return to IDLE. step pulses while busy are ignored, and enable=1 is ignored.
- Abort/wrap: abort on the last clock of phase 3 -> next clock idle, no cycle_done, count unchanged. With CYC_W=2, run 5 cycles -> cycle_count goes 1,2,3,0,1.
